s4_actividad2: RTL and testbench



---
 rtl/s4_actividad2.sv | 63 ++++++
 tb/tb_s4_actividad2.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/s4_actividad2.sv
// N-bit up/down counter with parallel load and a live threshold compare.
// Define S4_ACTIVIDAD2_SAT_EN for saturating instead of wrap-around counting.
module s4_actividad2 #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         dec,
    input  logic         load,
    input  logic [N-1:0] load_ref_value,
    output logic [N-1:0] counterN,
    output logic         threshold
);

    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO  = '0;
    localparam logic [N-1:0] MAXV  = '1;

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         at_max;
    logic         at_min;

    assign at_max = (count_q == MAXV);
    assign at_min = (count_q == ZERO);

    always_comb begin
        // NOTE: hold is assigned first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_ref_value;
        end else if (enable) begin
            if (dec) begin
`ifdef S4_ACTIVIDAD2_SAT_EN
                if (!at_min) count_d = count_q - ONE;
`else
                count_d = count_q - ONE;
`endif
            end else begin
`ifdef S4_ACTIVIDAD2_SAT_EN
                if (!at_max) count_d = count_q + ONE;
`else
                count_d = count_q + ONE;
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking assignment keeps register updates order-independent across processes.
        if (!reset) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign counterN  = count_q;
    // Compared against the live reference, so it reacts to either operand without a clock.
    assign threshold = (count_q >= load_ref_value);

endmodule

// File: tb/tb_s4_actividad2.sv
// Self-checking bench for s4_actividad2: directed steps plus randomized traffic
// against an integer reference model (honours S4_ACTIVIDAD2_SAT_EN).
module tb_s4_actividad2;

    localparam int N    = 4;
    localparam int MODV = 1 << N;
    localparam int TOPV = MODV - 1;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         dec;
    logic         load;
    logic [N-1:0] load_ref_value;
    logic [N-1:0] counterN;
    logic         threshold;

    int checks;
    int errors;
    int model_cnt;

    s4_actividad2 #(.N(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .dec            (dec),
        .load           (load),
        .load_ref_value (load_ref_value),
        .counterN       (counterN),
        .threshold      (threshold)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference behaviour expressed directly as integer arithmetic.
    function automatic int model_next(int c);
        int r;
        if (!reset)       r = 0;
        else if (load)    r = int'(load_ref_value);
        else if (!enable) r = c;
        else if (!dec) begin
`ifdef S4_ACTIVIDAD2_SAT_EN
            r = (c >= TOPV) ? TOPV : c + 1;
`else
            r = (c + 1) % MODV;
`endif
        end else begin
`ifdef S4_ACTIVIDAD2_SAT_EN
            r = (c <= 0) ? 0 : c - 1;
`else
            r = (c + MODV - 1) % MODV;
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cnt"}, int'(counterN), model_cnt);
        check({tag, "_thr"}, int'(threshold), (model_cnt >= int'(load_ref_value)) ? 1 : 0);
    endtask

    // Inputs are set at the falling edge; the model advances at the rising edge
    // from the bench's own input values, and outputs are compared at the next falling edge.
    task automatic step(input string tag);
        @(posedge clock);
        model_cnt = model_next(model_cnt);
        @(negedge clock);
        check_outputs(tag);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        model_cnt      = 0;
        reset          = 1'b0;
        enable         = 1'b0;
        dec            = 1'b0;
        load           = 1'b0;
        load_ref_value = 4'd3;

        // Reset state, with reference 3 and then 0.
        #1;
        check_outputs("reset_ref3");
        load_ref_value = 4'd0;
        #1;
        check_outputs("reset_ref0");
        load_ref_value = 4'd3;
        @(negedge clock);
        step("reset_held");
        reset = 1'b1;

        // Up-count through a full wrap (or saturation).
        enable = 1'b1;
        dec    = 1'b0;
        for (int i = 0; i < 20; i++) step("up");

        // Idle: nothing changes regardless of direction.
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dec = 1'($urandom_range(0, 1));
            step("idle");
        end

        // Down-count from 2 across zero.
        load_ref_value = 4'd2;
        load = 1'b1;
        step("load2");
        load = 1'b0;
        load_ref_value = 4'd3;
        enable = 1'b1;
        dec    = 1'b1;
        for (int i = 0; i < 4; i++) step("down");

        // Load priority over every enable/dec combination, held for two edges.
        load_ref_value = 4'd3;
        for (int k = 0; k < 4; k++) begin
            enable = 1'(k >> 1);
            dec    = 1'(k);
            load   = 1'b0;
            step("pre_load");
            load   = 1'b1;
            step("load_prio");
            step("load_hold");
        end
        load = 1'b0;

        // Asynchronous reset mid-count at 7.
        load_ref_value = 4'd7;
        load = 1'b1;
        step("load7");
        load = 1'b0;
        enable = 1'b1;
        dec = 1'b0;
        load_ref_value = 4'd3;
        #1;
        reset = 1'b0;
        model_cnt = 0;
        #1;
        check_outputs("async_reset");

        // Reset dominance over all enable/load/dec combinations.
        load_ref_value = 4'd9;
        @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            enable = 1'(k >> 2);
            load   = 1'(k >> 1);
            dec    = 1'(k);
            step("reset_dom");
        end
        enable = 1'b0;
        load   = 1'b0;
        reset  = 1'b1;
        step("reset_release");

        // Randomized traffic, including live threshold reference changes.
        for (int i = 0; i < 300; i++) begin
            enable         = 1'($urandom_range(0, 3) != 0);
            dec            = 1'($urandom_range(0, 1));
            load           = 1'($urandom_range(0, 7) == 0);
            load_ref_value = N'($urandom_range(0, TOPV));
            #1;
            check_outputs("rand_live");
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
